clk_period_meter: RTL and testbench
===================================

# clk_period_meter

Measures the period of a free-running clock, such as the output of the HDL clock generator, in cycles of the local reference clock. Each measured period is checked against a programmable window and delivered over a valid/ready interface. The block sits directly downstream of the clock generator, so a bench can confirm the generated frequency without sampling it in Python. A stopped clock is reported as an overflow result.

## Interface
- CNT_WIDTH, 16: width of the period counter and all period/limit buses.
- SYNC_STAGES, 2: synchronizer depth for meas_clk (legal range 2..4).
- clk  in  1  reference clock; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  1 = measure; 0 = idle.
- meas_clk  in  1  clock under measurement, asynchronous to clk.
- min_period  in  CNT_WIDTH  smallest in-range period, inclusive.
- max_period  in  CNT_WIDTH  largest in-range period, inclusive.
- period  out  CNT_WIDTH  measured period in clk cycles.
- period_valid  out  1  period, out_of_range and overflow are valid.
- period_ready  in  1  consumer accepts the result.
- out_of_range  out  1  the result is below min_period, above max_period, or an overflow.
- overflow  out  1  the counter saturated; no edge was seen within 2^CNT_WIDTH-1 cycles.
- err_sticky  out  1  set by any out-of-range measurement.
- dropped  out  1  sticky; a result was discarded because the output was still held.
- clear_err  in  1  clears err_sticky and dropped.

## Operation
- Synchronizer: SYNC_STAGES flops, all reset to 0.
- Edge register `prev` holds the last synchronized sample and resets to 1. Because of this, a meas_clk that is high at reset release does not produce a false edge.
- edge = sync_out & ~prev.
- FSM states:
  - IDLE: counter is 0. Go to ARM when enable=1.
  - ARM: wait for an edge. On an edge, set cnt to 1 and go to MEASURE. No result is produced from ARM.
  - MEASURE, no edge: cnt increments by 1.
  - MEASURE, edge: capture result = cnt and set cnt to 1. Stay in MEASURE.
  - MEASURE, cnt reaches 2^CNT_WIDTH-1 with no edge: capture result = all-ones with overflow=1 and go to ARM.
- enable=0 in any state: go to IDLE next cycle and clear the counter. A pending output result is kept and is still delivered.
- Result check, evaluated on capture: out_of_range = overflow | (result < min_period) | (result > max_period). Comparisons are unsigned. If min_period > max_period, every result is out of range.
- Output register:
  - A capture loads period/out_of_range/overflow and sets period_valid when the register is empty, or when period_valid & period_ready in the same cycle.
  - Otherwise the new result is discarded, the register is unchanged and dropped is set.
  - period_valid clears on period_valid & period_ready when there is no simultaneous capture.
  - Outputs are stable while period_valid=1 and period_ready=0.
- err_sticky is set by any captured out-of-range result, including a dropped one.
- clear_err clears err_sticky and dropped. If a set and a clear occur in the same cycle, the set wins.

## Timing
- Reset values:
  - period=0, period_valid=0, out_of_range=0, overflow=0, err_sticky=0, dropped=0.
  - FSM in IDLE, cnt=0.
- Latency from a meas_clk rising edge to the edge pulse: SYNC_STAGES to SYNC_STAGES+1 clk cycles, depending on phase.
- period_valid rises one cycle after the edge cycle.
- For a steady meas_clk period of P clk cycles, results alternate between floor(P) and ceil(P) and are exact for integer P.
- Periods shorter than 2 clk cycles, or high/low phases shorter than 1 clk cycle, are outside the measurable range; results for them are undefined.
- The first result arrives at the second detected edge after enable rises.
- rst_n asserted mid-measurement clears everything immediately, including any pending result.

## Test plan
- clk period 2 ns, meas_clk 10 ns, window 4..6, ready held high: the first result is period=5, valid for one cycle at a time, out_of_range=0. All subsequent results are 5.
- meas_clk 14 ns, window 4..6: period=7, out_of_range=1, err_sticky=1. A clear_err pulse then returns err_sticky to 0.
- CNT_WIDTH=8, meas_clk stopped after arming: after 255 cycles, period=255, overflow=1, out_of_range=1. The FSM re-arms and no further result appears until an edge arrives.
- period_ready=0 for 30 cycles with meas_clk 10 ns: the first result is held stable and dropped=1. After ready rises, the next accepted result is 5.
- meas_clk held high through reset release, then toggling at 10 ns: there is no spurious short result, and the first period is 5.
- enable dropped mid-measurement, then re-raised: no result is produced from the partial period, and the next result needs two new edges.

Source files
------------

// File: rtl/clk_period_meter_if.sv
// Result channel of the clock period meter: one measured period plus its
// range/overflow flags, delivered with a valid/ready handshake.
interface clk_period_meter_if #(
  parameter int CNT_WIDTH = 16
);
  logic [CNT_WIDTH-1:0] period;
  logic                 period_valid;
  logic                 period_ready;
  logic                 out_of_range;
  logic                 overflow;

  // Producer side (the meter)
  modport master (
    output period,
    output period_valid,
    output out_of_range,
    output overflow,
    input  period_ready
  );

  // Consumer side
  modport slave (
    input  period,
    input  period_valid,
    input  out_of_range,
    input  overflow,
    output period_ready
  );
endinterface

// File: rtl/clk_period_meter.sv
// Clock period meter: counts reference-clock cycles between successive
// rising edges of an asynchronous clock, checks each result against a
// min/max window and hands it out through a single-entry output register.
// A clock that stops for 2^CNT_WIDTH-1 cycles yields an all-ones overflow.
module clk_period_meter #(
  parameter int CNT_WIDTH   = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 meas_clk,
  input  logic [CNT_WIDTH-1:0] min_period,
  input  logic [CNT_WIDTH-1:0] max_period,
  input  logic                 clear_err,
  output logic                 err_sticky,
  output logic                 dropped,
  clk_period_meter_if.master   res_if
);

  localparam int                   PRIME_W    = $clog2(SYNC_STAGES + 1);
  localparam logic [PRIME_W-1:0]   PRIME_DONE = PRIME_W'(SYNC_STAGES);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_MEASURE
  } state_t;

  // Edge detection
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic [PRIME_W-1:0]     prime_q;
  logic                   sync_out;
  logic                   edge_w;

  // Measurement FSM
  state_t                 state_q;
  logic [CNT_WIDTH-1:0]   cnt_q;

  // Capture decode
  logic                   cap_d;
  logic                   cap_ovf_d;
  logic                   cap_oor_d;
  logic [CNT_WIDTH-1:0]   cap_val_d;

  // Output register and status
  logic [CNT_WIDTH-1:0]   period_q;
  logic                   valid_q;
  logic                   oor_q;
  logic                   ovf_q;
  logic                   err_q;
  logic                   drop_q;
  logic                   accept;
  logic                   load;
  logic                   discard;

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign edge_w   = sync_out & ~prev_q;

  // Bring meas_clk into the clk domain through a plain flop chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], meas_clk};
    end
  end

  // Track the previous synchronized level. The chain comes out of reset full
  // of zeros, so a meas_clk that is already high would otherwise look like a
  // 0->1 transition once it reaches the end; prev is therefore pinned high
  // until the chain holds only post-reset samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q  <= 1'b1;
      prime_q <= '0;
    end else if (prime_q == PRIME_DONE) begin
      prev_q  <= sync_out;
    end else begin
      prev_q  <= 1'b1;
      prime_q <= prime_q + 1'b1;
    end
  end

  // Decide whether this cycle produces a result and how it grades.
  always_comb begin
    cap_d     = 1'b0;
    cap_ovf_d = 1'b0;
    cap_val_d = cnt_q;
    if (enable && (state_q == S_MEASURE)) begin
      if (edge_w) begin
        cap_d = 1'b1;
      end else if (cnt_q == CNT_MAX) begin
        cap_d     = 1'b1;
        cap_ovf_d = 1'b1;
        cap_val_d = CNT_MAX;
      end
    end
    cap_oor_d = cap_ovf_d | (cap_val_d < min_period) | (cap_val_d > max_period);
  end

  // Measurement FSM: idle, wait for the first edge, then count edge to edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else if (!enable) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_q <= S_ARM;
          cnt_q   <= '0;
        end
        S_ARM: begin
          if (edge_w) begin
            state_q <= S_MEASURE;
            cnt_q   <= CNT_ONE;
          end
        end
        S_MEASURE: begin
          if (edge_w) begin
            cnt_q <= CNT_ONE;
          end else if (cnt_q == CNT_MAX) begin
            // Stopped clock: the overflow result is taken above, restart
            // from a fresh first edge.
            state_q <= S_ARM;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // A result may enter the output register only if it is empty or being
  // emptied this very cycle; otherwise it is thrown away.
  assign accept  = valid_q & res_if.period_ready;
  assign load    = cap_d & (~valid_q | accept);
  assign discard = cap_d & ~load;

  // Single-entry output register, held stable while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_q <= '0;
      valid_q  <= 1'b0;
      oor_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (load) begin
      period_q <= cap_val_d;
      valid_q  <= 1'b1;
      oor_q    <= cap_oor_d;
      ovf_q    <= cap_ovf_d;
    end else if (accept) begin
      valid_q  <= 1'b0;
    end
  end

  // Sticky status flags; a new event in the same cycle beats clear_err.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q  <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      if (cap_d && cap_oor_d) begin
        err_q <= 1'b1;
      end else if (clear_err) begin
        err_q <= 1'b0;
      end
      if (discard) begin
        drop_q <= 1'b1;
      end else if (clear_err) begin
        drop_q <= 1'b0;
      end
    end
  end

  assign res_if.period       = period_q;
  assign res_if.period_valid = valid_q;
  assign res_if.out_of_range = oor_q;
  assign res_if.overflow     = ovf_q;
  assign err_sticky          = err_q;
  assign dropped             = drop_q;

endmodule

// File: tb/tb_clk_period_meter.sv
// Bench for clk_period_meter: directed scenarios plus a randomized run,
// checked every cycle against a timestamp-based reference model.
module tb_clk_period_meter;

  localparam int CW   = 8;
  localparam int SS   = 2;
  localparam int MAXV = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          meas_clk = 1'b0;
  logic          clear_err = 1'b0;
  logic [CW-1:0] min_period = CW'(4);
  logic [CW-1:0] max_period = CW'(6);
  logic          err_sticky;
  logic          dropped;

  clk_period_meter_if #(.CNT_WIDTH(CW)) bus ();

  clk_period_meter #(.CNT_WIDTH(CW), .SYNC_STAGES(SS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .meas_clk   (meas_clk),
    .min_period (min_period),
    .max_period (max_period),
    .clear_err  (clear_err),
    .err_sticky (err_sticky),
    .dropped    (dropped),
    .res_if     (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // meas_clk generator, synchronous to the falling edge of clk
  bit gen_on    = 1'b0;
  bit rand_mode = 1'b0;
  bit lvl       = 1'b0;
  int hi_len    = 2;
  int lo_len    = 3;
  int ph_cnt    = 0;

  function automatic int pick_len();
    if ($urandom_range(0, 49) == 0) return int'($urandom_range(100, 300));
    return int'($urandom_range(1, 8));
  endfunction

  always @(negedge clk) begin
    if (gen_on) begin
      if (ph_cnt <= 1) begin
        lvl = ~lvl;
        if (lvl && rand_mode) begin
          hi_len = pick_len();
          lo_len = pick_len();
        end
        ph_cnt = lvl ? hi_len : lo_len;
      end else begin
        ph_cnt = ph_cnt - 1;
      end
      meas_clk = lvl;
    end
  end

  // Reference model: edges are timestamps, results are timestamp differences.
  localparam int M_IDLE = 0;
  localparam int M_ARM  = 1;
  localparam int M_RUN  = 2;

  bit            hist[$];
  int            m_mode;
  int            ncyc;
  int            last_edge;
  bit            m_edge, m_cap, m_ovf, m_oor, m_acc, m_drop_now;
  int            m_res;
  bit            e_valid, e_oor, e_ovf, e_err, e_drop;
  logic [CW-1:0] e_period;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist.delete();
      m_mode    = M_IDLE;
      ncyc      = 0;
      last_edge = 0;
      e_valid   = 1'b0;
      e_period  = '0;
      e_oor     = 1'b0;
      e_ovf     = 1'b0;
      e_err     = 1'b0;
      e_drop    = 1'b0;
    end else begin
      ncyc = ncyc + 1;
      hist.push_back(meas_clk);
      if (hist.size() > SS + 2) void'(hist.pop_front());
      // A rise sampled at cycle t is acted on at cycle t+SS.
      m_edge = (hist.size() == SS + 2) && hist[1] && !hist[0];
      m_cap = 1'b0;
      m_ovf = 1'b0;
      m_res = 0;
      if (!enable) begin
        m_mode = M_IDLE;
      end else if (m_mode == M_IDLE) begin
        m_mode = M_ARM;
      end else if (m_mode == M_ARM) begin
        if (m_edge) begin
          last_edge = ncyc;
          m_mode    = M_RUN;
        end
      end else begin
        if (m_edge) begin
          m_cap     = 1'b1;
          m_res     = ncyc - last_edge;
          last_edge = ncyc;
        end else if (ncyc - last_edge == MAXV) begin
          m_cap  = 1'b1;
          m_ovf  = 1'b1;
          m_res  = MAXV;
          m_mode = M_ARM;
        end
      end
      m_oor = m_ovf || (m_res < int'(min_period)) || (m_res > int'(max_period));
      m_acc = e_valid && bus.period_ready;
      m_drop_now = 1'b0;
      if (m_cap) begin
        if (!e_valid || m_acc) begin
          e_valid  = 1'b1;
          e_period = CW'(m_res);
          e_oor    = m_oor;
          e_ovf    = m_ovf;
        end else begin
          m_drop_now = 1'b1;
        end
      end else if (m_acc) begin
        e_valid = 1'b0;
      end
      if (m_cap && m_oor) e_err = 1'b1;
      else if (clear_err) e_err = 1'b0;
      if (m_drop_now) e_drop = 1'b1;
      else if (clear_err) e_drop = 1'b0;
    end
  end

  // Per-cycle comparison of every output against the model
  always @(posedge clk) begin
    #1;
    n_checks = n_checks + 1;
    if (bus.period_valid !== e_valid || bus.period !== e_period ||
        bus.out_of_range !== e_oor || bus.overflow !== e_ovf ||
        err_sticky !== e_err || dropped !== e_drop) begin
      n_fail = n_fail + 1;
      $display("FAIL cycle_cmp t=%0t: dut v=%b p=%0d oor=%b ovf=%b err=%b drop=%b, model v=%b p=%0d oor=%b ovf=%b err=%b drop=%b",
               $time, bus.period_valid, bus.period, bus.out_of_range, bus.overflow, err_sticky, dropped,
               e_valid, e_period, e_oor, e_ovf, e_err, e_drop);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_valid(input string name, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      if (bus.period_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_checks = n_checks + 1;
      n_fail   = n_fail + 1;
      $display("FAIL %s: no result within %0d cycles, expected period_valid=1", name, budget);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit            ok;
    int            changes;
    int            seen;
    int            lat;
    logic [CW-1:0] held;

    bus.period_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_valid",  32'(bus.period_valid), 32'd0);
    chk("rst_period", 32'(bus.period),       32'd0);
    chk("rst_oor",    32'(bus.out_of_range), 32'd0);
    chk("rst_ovf",    32'(bus.overflow),     32'd0);
    chk("rst_err",    32'(err_sticky),       32'd0);
    chk("rst_drop",   32'(dropped),          32'd0);
    rst_n = 1'b1;

    // Steady 5-cycle clock, window 4..6
    @(negedge clk);
    hi_len = 2; lo_len = 3; ph_cnt = 0; gen_on = 1'b1;
    enable = 1'b1;
    wait_valid("p5_first", 40, ok);
    if (ok) begin
      chk("p5_first_period", 32'(bus.period), 32'd5);
      chk("p5_first_oor",    32'(bus.out_of_range), 32'd0);
    end
    @(posedge clk); #1;
    chk("p5_valid_one_cycle", 32'(bus.period_valid), 32'd0);
    wait_valid("p5_second", 20, ok);
    if (ok) chk("p5_second_period", 32'(bus.period), 32'd5);

    // 7-cycle clock is above the window
    @(negedge clk);
    hi_len = 4; lo_len = 3;
    for (int k = 0; k < 3; k++) wait_valid("p7", 30, ok);
    if (ok) begin
      chk("p7_period", 32'(bus.period),       32'd7);
      chk("p7_oor",    32'(bus.out_of_range), 32'd1);
      chk("p7_err",    32'(err_sticky),       32'd1);
    end
    @(negedge clk); enable = 1'b0;
    @(negedge clk); clear_err = 1'b1;
    @(negedge clk); clear_err = 1'b0;
    @(posedge clk); #1;
    chk("clear_err", 32'(err_sticky), 32'd0);

    // Stopped clock after arming gives an overflow result
    @(negedge clk);
    hi_len = 2; lo_len = 3; enable = 1'b1;
    wait_valid("ovf_pre", 40, ok);
    if (ok) chk("ovf_pre_period", 32'(bus.period), 32'd5);
    @(negedge clk); gen_on = 1'b0;
    wait_valid("ovf", 300, ok);
    if (ok) begin
      chk("ovf_period", 32'(bus.period),       32'(MAXV));
      chk("ovf_flag",   32'(bus.overflow),     32'd1);
      chk("ovf_oor",    32'(bus.out_of_range), 32'd1);
    end
    seen = 0;
    repeat (60) begin
      @(posedge clk); #1;
      if (bus.period_valid === 1'b1) seen++;
    end
    chk("ovf_rearm_quiet", 32'(seen), 32'd0);

    // Backpressure: result held, later ones dropped
    @(negedge clk);
    bus.period_ready = 1'b0; gen_on = 1'b1;
    wait_valid("bp_first", 60, ok);
    held = bus.period;
    if (ok) chk("bp_first_period", 32'(held), 32'd5);
    changes = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (bus.period !== held || bus.period_valid !== 1'b1) changes++;
    end
    chk("bp_hold_stable", 32'(changes), 32'd0);
    chk("bp_dropped",     32'(dropped), 32'd1);
    @(negedge clk); bus.period_ready = 1'b1;
    wait_valid("bp_next", 20, ok);
    if (ok) chk("bp_next_period", 32'(bus.period), 32'd5);
    @(negedge clk); clear_err = 1'b1;
    @(negedge clk); clear_err = 1'b0;

    // Reset with a pending result and meas_clk held high through release
    @(negedge clk); bus.period_ready = 1'b0;
    wait_valid("pre_rst", 20, ok);
    @(negedge clk);
    gen_on = 1'b0; lvl = 1'b1; meas_clk = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", 32'(bus.period_valid), 32'd0);
    chk("rst_mid_drop",  32'(dropped),          32'd0);
    repeat (3) @(negedge clk);
    bus.period_ready = 1'b1; rst_n = 1'b1;
    repeat (10) @(negedge clk);
    ph_cnt = 1; gen_on = 1'b1;
    wait_valid("high_at_reset", 60, ok);
    if (ok) chk("high_at_reset_period", 32'(bus.period), 32'd5);

    // enable dropped mid-measurement, then restored
    wait_valid("en_pre", 20, ok);
    repeat (2) @(negedge clk);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    enable = 1'b1;
    lat = 0;
    ok  = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      lat++;
      if (bus.period_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    chk("en_restart_seen", 32'(ok), 32'd1);
    if (ok) begin
      chk("en_restart_period",  32'(bus.period), 32'd5);
      chk("en_restart_latency", 32'(lat >= 7),   32'd1);
    end

    // Randomized traffic checked by the model every cycle
    rand_mode = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      bus.period_ready = ($urandom_range(0, 3) != 0);
      clear_err = ($urandom_range(0, 40) == 0);
      if ($urandom_range(0, 150) == 0) enable = ~enable;
      if ($urandom_range(0, 200) == 0) begin
        min_period = CW'($urandom_range(0, 12));
        max_period = CW'($urandom_range(0, 12));
      end
    end
    @(negedge clk);
    gen_on = 1'b0; clear_err = 1'b0;
    repeat (5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
